// File: rtl/blink_sequencer.sv
// Pattern engine that drives enable and frequency words for four LED toggle channels.
// Steps advance every latched dwell count of clk cycles; pause freezes, stop aborts.
module blink_sequencer #(
  parameter logic [31:0] FREQ_0  = 32'd25,
  parameter logic [31:0] FREQ_1  = 32'd50,
  parameter logic [31:0] FREQ_2  = 32'd75,
  parameter logic [31:0] FREQ_3  = 32'd100,
  parameter int unsigned DWELL_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_pause,
  input  logic [1:0]         i_mode,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [3:0]         o_enable,
  output logic [31:0]        o_freq_0,
  output logic [31:0]        o_freq_1,
  output logic [31:0]        o_freq_2,
  output logic [31:0]        o_freq_3,
  output logic               o_busy,
  output logic               o_step
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               step_q, step_d;
  logic [31:0]        freq0_q, freq1_q, freq2_q, freq3_q;

  function automatic logic [3:0] pattern(input logic [1:0] mode, input logic [3:0] idx);
    logic [3:0] p;
    p = 4'b0000;
    case (mode)
      2'd0: p = 4'b1111;
      2'd1: p = 4'b0001 << idx[1:0];
      2'd2: begin
        case (idx)
          4'd0:    p = 4'b0001;
          4'd1:    p = 4'b0010;
          4'd2:    p = 4'b0100;
          4'd3:    p = 4'b1000;
          4'd4:    p = 4'b0100;
          default: p = 4'b0010;
        endcase
      end
      default: p = idx + 4'd1;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] mode);
    logic [3:0] l;
    case (mode)
      2'd0:    l = 4'd0;
      2'd1:    l = 4'd3;
      2'd2:    l = 4'd5;
      default: l = 4'd14;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    step_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        enable_d = '0;
        busy_d   = 1'b0;
        if (i_start && !i_stop) begin
          mode_d   = i_mode;
          dwell_d  = (i_dwell == '0) ? DWELL_ONE : i_dwell;
          idx_d    = '0;
          cnt_d    = '0;
          enable_d = pattern(i_mode, 4'd0);
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      default: begin
        // The edge leaving HOLD counts like a RUN edge, so a pause of P cycles delays by exactly P.
        if (i_stop) begin
          state_d  = S_IDLE;
          enable_d = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
          idx_d    = '0;
        end else if (i_pause) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
          if (cnt_q == dwell_q - DWELL_ONE) begin
            cnt_d    = '0;
            idx_d    = (idx_q == last_idx(mode_q)) ? 4'd0 : idx_q + 4'd1;
            enable_d = pattern(mode_q, idx_d);
            step_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + DWELL_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      dwell_q  <= DWELL_ONE;
      cnt_q    <= '0;
      idx_q    <= '0;
      enable_q <= '0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    freq0_q <= FREQ_0;
    freq1_q <= FREQ_1;
    freq2_q <= FREQ_2;
    freq3_q <= FREQ_3;
  end

  assign o_enable = enable_q;
  assign o_busy   = busy_q;
  assign o_step   = step_q;
  assign o_freq_0 = freq0_q;
  assign o_freq_1 = freq1_q;
  assign o_freq_2 = freq2_q;
  assign o_freq_3 = freq3_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer: pattern timing, pause, stop/start collisions, dwell edges.
module tb_blink_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_stop, i_pause;
  logic [1:0]  i_mode;
  logic [31:0] i_dwell;
  logic [3:0]  o_enable;
  logic [31:0] o_freq_0, o_freq_1, o_freq_2, o_freq_3;
  logic        o_busy, o_step;

  int passed = 0;
  int total  = 0;

  blink_sequencer #(
    .FREQ_0(32'd25), .FREQ_1(32'd50), .FREQ_2(32'd75), .FREQ_3(32'd100), .DWELL_W(32)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop), .i_pause(i_pause),
    .i_mode(i_mode), .i_dwell(i_dwell), .o_enable(o_enable),
    .o_freq_0(o_freq_0), .o_freq_1(o_freq_1), .o_freq_2(o_freq_2), .o_freq_3(o_freq_3),
    .o_busy(o_busy), .o_step(o_step)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] mode, input logic [31:0] dwell);
    i_start = 1'b1; i_mode = mode; i_dwell = dwell;
    tick();
    i_start = 1'b0;
  endtask

  task automatic stop;
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0; i_mode = 2'd0; i_dwell = 32'd1;
    tick(); tick();
    reset = 1'b0;
    total++; if (o_enable !== 4'b0000) $display("FAIL reset_enable: got %b want 0000", o_enable); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else passed++;
    total++; if (o_step !== 1'b0) $display("FAIL reset_step: got %b want 0", o_step); else passed++;
    total++;
    if (o_freq_0 !== 32'd25 || o_freq_1 !== 32'd50 || o_freq_2 !== 32'd75 || o_freq_3 !== 32'd100)
      $display("FAIL reset_freq: got %0d/%0d/%0d/%0d want 25/50/75/100", o_freq_0, o_freq_1, o_freq_2, o_freq_3);
    else passed++;
  endtask

  task automatic test_chase;
    logic [3:0] exp_en [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    start(2'd1, 32'd3);
    for (int t = 0; t < 13; t++) begin
      total++;
      if (o_enable !== exp_en[(t / 3) % 4]) $display("FAIL chase_en t=%0d: got %b want %b", t, o_enable, exp_en[(t / 3) % 4]);
      else passed++;
      total++;
      if (o_step !== (t > 0 && t % 3 == 0)) $display("FAIL chase_step t=%0d: got %b want %b", t, o_step, (t > 0 && t % 3 == 0));
      else passed++;
      total++; if (o_busy !== 1'b1) $display("FAIL chase_busy t=%0d: got %b want 1", t, o_busy); else passed++;
      tick();
    end
    stop();
    total++; if (o_enable !== 4'b0000 || o_busy !== 1'b0) $display("FAIL chase_stop: got en=%b busy=%b want 0000/0", o_enable, o_busy); else passed++;
  endtask

  task automatic test_bounce_count;
    logic [3:0] exp_b [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    start(2'd2, 32'd1);
    for (int t = 0; t < 7; t++) begin
      total++; if (o_enable !== exp_b[t]) $display("FAIL bounce_en t=%0d: got %b want %b", t, o_enable, exp_b[t]); else passed++;
      total++; if (o_step !== (t > 0)) $display("FAIL bounce_step t=%0d: got %b want %b", t, o_step, (t > 0)); else passed++;
      tick();
    end
    stop();
    start(2'd3, 32'd1);
    for (int t = 0; t < 16; t++) begin
      total++;
      if (o_enable !== 4'((t % 15) + 1)) $display("FAIL count_en t=%0d: got %b want %b", t, o_enable, 4'((t % 15) + 1));
      else passed++;
      tick();
    end
    stop();
  endtask

  task automatic test_pause;
    start(2'd1, 32'd5);
    tick(); tick();
    i_pause = 1'b1;
    for (int t = 0; t < 7; t++) begin
      tick();
      total++;
      if (o_enable !== 4'b0001 || o_step !== 1'b0 || o_busy !== 1'b1)
        $display("FAIL pause_hold t=%0d: got en=%b step=%b busy=%b want 0001/0/1", t, o_enable, o_step, o_busy);
      else passed++;
    end
    i_pause = 1'b0;
    tick();
    total++; if (o_enable !== 4'b0001 || o_step !== 1'b0) $display("FAIL pause_rel1: got en=%b step=%b want 0001/0", o_enable, o_step); else passed++;
    tick();
    total++; if (o_enable !== 4'b0001 || o_step !== 1'b0) $display("FAIL pause_rel2: got en=%b step=%b want 0001/0", o_enable, o_step); else passed++;
    tick();
    total++; if (o_enable !== 4'b0010 || o_step !== 1'b1) $display("FAIL pause_adv: got en=%b step=%b want 0010/1", o_enable, o_step); else passed++;
    i_pause = 1'b1;
    tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0; i_pause = 1'b0;
    total++;
    if (o_enable !== 4'b0000 || o_busy !== 1'b0 || o_step !== 1'b0)
      $display("FAIL stop_in_hold: got en=%b busy=%b step=%b want 0000/0/0", o_enable, o_busy, o_step);
    else passed++;
  endtask

  task automatic test_collisions;
    i_start = 1'b1; i_stop = 1'b1; i_mode = 2'd1; i_dwell = 32'd2;
    tick(); tick();
    i_start = 1'b0; i_stop = 1'b0;
    total++; if (o_busy !== 1'b0 || o_enable !== 4'b0000) $display("FAIL start_stop_idle: got busy=%b en=%b want 0/0000", o_busy, o_enable); else passed++;
    start(2'd1, 32'd2);
    i_start = 1'b1; i_mode = 2'd0; i_dwell = 32'd1;
    for (int t = 0; t < 5; t++) begin
      total++;
      if (o_enable !== (4'b0001 << (t / 2))) $display("FAIL start_in_run t=%0d: got %b want %b", t, o_enable, 4'b0001 << (t / 2));
      else passed++;
      tick();
    end
    i_start = 1'b0;
    stop();
  endtask

  task automatic test_dwell_edge;
    logic [3:0] exp_c [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    start(2'd1, 32'd0);
    for (int t = 0; t < 5; t++) begin
      total++;
      if (o_enable !== exp_c[t] || o_step !== (t > 0)) $display("FAIL dwell0 t=%0d: got en=%b step=%b want %b/%b", t, o_enable, o_step, exp_c[t], (t > 0));
      else passed++;
      tick();
    end
    stop();
    start(2'd0, 32'd2);
    for (int t = 0; t < 7; t++) begin
      total++;
      if (o_enable !== 4'b1111 || o_step !== (t > 0 && t % 2 == 0))
        $display("FAIL mode0 t=%0d: got en=%b step=%b want 1111/%b", t, o_enable, o_step, (t > 0 && t % 2 == 0));
      else passed++;
      tick();
    end
    stop();
    start(2'd1, 32'hFFFF_FFFF);
    for (int t = 0; t < 6; t++) tick();
    total++; if (o_enable !== 4'b0001 || o_step !== 1'b0 || o_busy !== 1'b1) $display("FAIL max_dwell: got en=%b step=%b busy=%b want 0001/0/1", o_enable, o_step, o_busy); else passed++;
    stop();
  endtask

  task automatic test_reset_midrun;
    start(2'd1, 32'd4);
    for (int t = 0; t < 9; t++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (o_enable !== 4'b0000 || o_busy !== 1'b0 || o_step !== 1'b0)
      $display("FAIL midrun_reset: got en=%b busy=%b step=%b want 0000/0/0", o_enable, o_busy, o_step);
    else passed++;
    total++;
    if (o_freq_0 !== 32'd25 || o_freq_1 !== 32'd50 || o_freq_2 !== 32'd75 || o_freq_3 !== 32'd100)
      $display("FAIL midrun_freq: got %0d/%0d/%0d/%0d want 25/50/75/100", o_freq_0, o_freq_1, o_freq_2, o_freq_3);
    else passed++;
    start(2'd1, 32'd4);
    total++; if (o_enable !== 4'b0001 || o_busy !== 1'b1) $display("FAIL restart: got en=%b busy=%b want 0001/1", o_enable, o_busy); else passed++;
    stop();
  endtask

  initial begin
    test_reset();
    test_chase();
    test_bounce_count();
    test_pause();
    test_collisions();
    test_dwell_edge();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
